param_clock_divider: RTL

//   Parametrised successor to the fixed 8-bit enabled counter: a programmable divide-by-N counter.

---
 rtl/clkdiv_pkg.sv | 7 +
 rtl/clkdiv_tc_detect.sv | 13 +
 rtl/param_clock_divider.sv | 72 +++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared state encoding, direction codes and default divisor for param_clock_divider.
package clkdiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int DIV_DEFAULT_VAL = 9;
endpackage

// File: rtl/clkdiv_tc_detect.sv
// clkdiv_tc_detect: combinational terminal-count compare (>= shadow when counting up, zero when counting down).
module clkdiv_tc_detect
  import clkdiv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] div_shadow,
  input  logic             up_down,
  output logic             tc
);
  assign tc = (up_down == DIR_UP) ? (count >= div_shadow) : (count == '0);
endmodule

// File: rtl/param_clock_divider.sv
// param_clock_divider: programmable divide-by-(N+1) up/down counter with load, tick pulse and divided clock enable.
// Optional one-shot mode (input oneshot, output done) is enabled by defining CLKDIV_ONESHOT_EN.
module param_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIV_DEFAULT = DIV_DEFAULT_VAL
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  input  logic [WIDTH-1:0] divisor,
`ifdef CLKDIV_ONESHOT_EN
  input  logic             oneshot,
  output logic             done,
`endif
  output logic [WIDTH-1:0] count_out,
  output logic             tick,
  output logic             div_clk
);
  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] div_shadow;
  logic             tc;
  logic             os;
  logic             active;
`ifdef CLKDIV_ONESHOT_EN
  assign os = oneshot;
`else
  assign os = 1'b0;
`endif
  clkdiv_tc_detect #(.WIDTH(WIDTH)) u_tc (
    .count      (count_out),
    .div_shadow (div_shadow),
    .up_down    (up_down),
    .tc         (tc)
  );
  // A load always wins; a finished one-shot ignores enable until reloaded or disabled.
  assign active = !load && enable && (state != DONE);
  always_comb
    state_nxt = load ? (enable ? RUN : IDLE) :
                !enable ? IDLE :
                ((state == DONE) || (tc && os)) ? DONE : RUN;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      count_out  <= '0;
      tick       <= 1'b0;
      div_clk    <= 1'b0;
      div_shadow <= WIDTH'(DIV_DEFAULT);
      state      <= IDLE;
    end else begin
      state <= state_nxt;
      tick  <= active && tc;
      if (load) begin
        count_out  <= load_value;
        div_shadow <= divisor;
      end else if (active && tc) begin
        count_out  <= (up_down == DIR_UP) ? '0 : divisor;
        div_shadow <= divisor;
        div_clk    <= ~div_clk;
      end else if (active)
        count_out <= (up_down == DIR_UP) ? count_out + 1'b1 : count_out - 1'b1;
    end
`ifdef CLKDIV_ONESHOT_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) done <= 1'b0;
    else done <= (state_nxt == DONE);
`endif
endmodule
